usr_burst: RTL and testbench

//  Parametrised universal shift register with a self-timed burst engine.

---
 rtl/usr_burst.sv | 141 ++++++++++++++
 tb/tb_usr_burst.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/usr_burst.sv
// Universal shift register (hold/shift/rotate/ASR/load) with a self-timed burst engine.
// Latency: one cycle; every result appears on PAR_OUT/SER_OUT the cycle after its operating edge.
// Backpressure: none; START is ignored while a burst runs, and BUSY tells the caller when it may start again.
module usr_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic             SER_IN,
    input  logic [WIDTH-1:0] PAR_IN,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             SER_OUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               ser_q, ser_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               done_q, done_d;

    // Reset and clear are both synchronous and have the same effect.
    logic               wipe;
    logic               last_op;
    logic               op_go;
    logic [2:0]         op_mode;

    assign wipe    = !RST || !CLR;
    assign last_op = (state_q == S_RUN) && (cnt_q == CNT_W'(1));

    // State register and all datapath flops; reset is folded into the _d logic.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        r_q     <= r_d;
        ser_q   <= ser_d;
        cnt_q   <= cnt_d;
        mode_q  <= mode_d;
        done_q  <= done_d;
    end

    // Next state: a burst leaves RUN on the edge doing its last op; a zero-length START never enters RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START && (COUNT != '0)) state_d = S_RUN;
            S_RUN:   if (last_op) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wipe) state_d = S_IDLE;
    end

    // Datapath and outputs: pick which op (if any) happens this edge, then apply it.
    always_comb begin
        r_d     = r_q;
        ser_d   = ser_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        op_go   = 1'b0;
        op_mode = MODE;

        if (state_q == S_RUN) begin
            // Running bursts use the latched mode and ignore EN/MODE/START entirely.
            op_go   = 1'b1;
            op_mode = mode_q;
            cnt_d   = cnt_q - CNT_W'(1);
            done_d  = last_op;
        end else if (START) begin
            // The START edge only latches; it never performs an op, even with EN high.
            if (COUNT != '0) begin
                mode_d = MODE;
                cnt_d  = COUNT;
            end else begin
                done_d = 1'b1;
            end
        end else if (EN) begin
            op_go = 1'b1;
        end

        if (op_go) begin
            case (op_mode)
                M_SHR: begin
                    r_d   = {SER_IN, r_q[WIDTH-1:1]};
                    ser_d = r_q[0];
                end
                M_SHL: begin
                    r_d   = {r_q[WIDTH-2:0], SER_IN};
                    ser_d = r_q[WIDTH-1];
                end
                M_ROR: begin
                    r_d   = {r_q[0], r_q[WIDTH-1:1]};
                    ser_d = r_q[0];
                end
                M_ROL: begin
                    r_d   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    ser_d = r_q[WIDTH-1];
                end
                M_ASR: begin
                    r_d   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    ser_d = r_q[0];
                end
                M_LOAD:  r_d = PAR_IN;
                default: r_d = r_q;
            endcase
        end

        if (wipe) begin
            r_d    = '0;
            ser_d  = 1'b0;
            cnt_d  = '0;
            mode_d = '0;
            done_d = 1'b0;
        end
    end

    assign PAR_OUT = r_q;
    assign SER_OUT = ser_q;
    assign BUSY    = (state_q == S_RUN);
    assign DONE    = done_q;

endmodule

// File: tb/tb_usr_burst.sv
// Directed vector bench for usr_burst at WIDTH=8, CNT_W=4.
// Each vector drives inputs for one edge and checks outputs 1ns after that edge.
// Multi-cycle corners (long burst, reset mid-burst) are hand-written sequences.
module tb_usr_burst;

    logic       CLK = 1'b0;
    logic       RST, CLR, EN, SER_IN, START;
    logic [2:0] MODE;
    logic [7:0] PAR_IN;
    logic [3:0] COUNT;
    logic [7:0] PAR_OUT;
    logic       SER_OUT, BUSY, DONE;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst, clr, en;
        logic [2:0] mode;
        logic       ser;
        logic [7:0] par;
        logic       start;
        logic [3:0] cnt;
        logic [7:0] e_par;
        logic       e_ser, e_busy, e_done;
    } vec_t;

    vec_t vq[$];

    usr_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .MODE(MODE),
        .SER_IN(SER_IN), .PAR_IN(PAR_IN), .START(START), .COUNT(COUNT),
        .PAR_OUT(PAR_OUT), .SER_OUT(SER_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic rst, input logic clr, input logic en, input logic [2:0] mode,
                       input logic ser, input logic [7:0] par, input logic start, input logic [3:0] cnt,
                       input logic [7:0] e_par, input logic e_ser, input logic e_busy, input logic e_done);
        vec_t v;
        v.rst = rst; v.clr = clr; v.en = en; v.mode = mode; v.ser = ser; v.par = par;
        v.start = start; v.cnt = cnt; v.e_par = e_par; v.e_ser = e_ser; v.e_busy = e_busy; v.e_done = e_done;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic clr, input logic en, input logic [2:0] mode,
                         input logic ser, input logic [7:0] par, input logic start, input logic [3:0] cnt);
        RST = rst; CLR = clr; EN = en; MODE = mode; SER_IN = ser; PAR_IN = par; START = start; COUNT = cnt;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got par=%h ser=%b busy=%b done=%b, want par=%h ser=%b busy=%b done=%b",
                     name, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    initial begin
        int busy_cycles;
        bit saw_done;

        //   rst  clr  en  mode  ser par    st  cnt   e_par e_ser busy done
        add(0, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, 0); // reset
        add(1, 1, 1, 3'd6, 0, 8'hA5, 0, 4'd0,  8'hA5, 0, 0, 0);
        add(1, 0, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, 0); // clear
        add(1, 1, 1, 3'd6, 0, 8'hA5, 0, 4'd0,  8'hA5, 0, 0, 0); // manual load
        add(1, 1, 1, 3'd1, 1, 8'h00, 0, 4'd0,  8'hD2, 1, 0, 0); // SHR
        add(1, 1, 1, 3'd6, 0, 8'h81, 0, 4'd0,  8'h81, 1, 0, 0); // load keeps SER_OUT
        add(1, 1, 1, 3'd4, 0, 8'h00, 1, 4'd3,  8'h81, 1, 1, 0); // START edge: no op despite EN
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h03, 1, 1, 0); // ROL burst
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h06, 0, 1, 0);
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h0C, 0, 0, 1);
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h0C, 0, 0, 0); // DONE only one cycle
        add(1, 1, 1, 3'd6, 0, 8'h90, 0, 4'd0,  8'h90, 0, 0, 0);
        add(1, 1, 1, 3'd5, 0, 8'h00, 0, 4'd0,  8'hC8, 0, 0, 0); // ASR
        add(1, 1, 1, 3'd5, 0, 8'h00, 0, 4'd0,  8'hE4, 0, 0, 0);
        add(1, 1, 0, 3'd1, 1, 8'h00, 1, 4'd5,  8'hE4, 0, 1, 0); // burst SHR x5
        add(1, 1, 0, 3'd0, 1, 8'h00, 0, 4'd0,  8'hF2, 0, 1, 0);
        add(1, 0, 0, 3'd0, 1, 8'h00, 0, 4'd0,  8'h00, 0, 0, 0); // abort by CLR
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, 0); // no DONE after abort
        add(1, 1, 1, 3'd6, 0, 8'h3C, 0, 4'd0,  8'h3C, 0, 0, 0);
        add(1, 1, 0, 3'd1, 0, 8'h00, 1, 4'd0,  8'h3C, 0, 0, 1); // COUNT=0
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h3C, 0, 0, 0);
        add(1, 1, 0, 3'd3, 0, 8'h00, 1, 4'd2,  8'h3C, 0, 1, 0); // ROR x2
        add(1, 1, 1, 3'd2, 1, 8'h00, 1, 4'd7,  8'h1E, 0, 1, 0); // START/MODE/EN ignored
        add(1, 1, 0, 3'd6, 0, 8'hFF, 1, 4'd7,  8'h0F, 0, 0, 1);
        add(1, 1, 0, 3'd4, 0, 8'h00, 1, 4'd1,  8'h0F, 0, 1, 0); // back-to-back START on DONE cycle
        add(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0,  8'h1E, 0, 0, 1);
        add(1, 1, 1, 3'd7, 1, 8'h00, 0, 4'd0,  8'h1E, 0, 0, 0); // reserved = hold
        add(1, 1, 1, 3'd2, 1, 8'h00, 0, 4'd0,  8'h3D, 0, 0, 0); // SHL
        add(1, 1, 1, 3'd6, 0, 8'h81, 0, 4'd0,  8'h81, 0, 0, 0);
        add(1, 1, 1, 3'd2, 0, 8'h00, 0, 4'd0,  8'h02, 1, 0, 0); // SHL out = MSB
        add(1, 1, 1, 3'd3, 0, 8'h00, 0, 4'd0,  8'h01, 0, 0, 0); // ROR

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].clr, vq[i].en, vq[i].mode, vq[i].ser, vq[i].par, vq[i].start, vq[i].cnt);
            tick();
            check($sformatf("vec%0d", i), {PAR_OUT, SER_OUT, BUSY, DONE},
                  {vq[i].e_par, vq[i].e_ser, vq[i].e_busy, vq[i].e_done});
        end

        // Long burst beyond WIDTH: 15 SHR ops filling with 1s from 0x01.
        drive(1, 1, 0, 3'd1, 1, 8'h00, 1, 4'd15);
        tick();
        drive(1, 1, 0, 3'd0, 1, 8'h00, 0, 4'd0);
        busy_cycles = 0;
        saw_done = 0;
        if (BUSY) busy_cycles++;
        tick();
        check("long_first", {PAR_OUT, SER_OUT, BUSY, DONE}, {8'h80, 1'b1, 1'b1, 1'b0});
        for (int c = 0; c < 40 && !saw_done; c++) begin
            if (BUSY) busy_cycles++;
            if (DONE) saw_done = 1;
            else tick();
        end
        check_int("long_done_seen", int'(saw_done), 1);
        check_int("long_busy_cycles", busy_cycles, 15);
        check("long_end", {PAR_OUT, SER_OUT, BUSY, DONE}, {8'hFF, 1'b1, 1'b0, 1'b1});

        // RST in the middle of a burst: everything returns to zero, no DONE.
        drive(1, 1, 0, 3'd4, 0, 8'h00, 1, 4'd4);
        tick();
        drive(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0);
        tick();
        check("rst_mid_run", {PAR_OUT, SER_OUT, BUSY, DONE}, {8'hFF, 1'b1, 1'b1, 1'b0});
        drive(0, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0);
        tick();
        check("rst_abort", {PAR_OUT, SER_OUT, BUSY, DONE}, {8'h00, 1'b0, 1'b0, 1'b0});
        drive(1, 1, 0, 3'd0, 0, 8'h00, 0, 4'd0);
        tick();
        tick();
        check("rst_no_done", {PAR_OUT, SER_OUT, BUSY, DONE}, {8'h00, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
